rob_commit_engine: RTL and testbench

//  Parametrised reorder buffer with multi-wide dispatch, multi-port completion writeback and in-order multi-wide commit.

---
 rtl/rob_commit_engine.sv | 188 ++++++++++++++++++
 tb/tb_rob_commit_engine.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_engine.sv
// Reorder buffer: multi-wide dispatch, multi-port writeback, in-order multi-wide commit, exception redirect.
// Optional ROB_COMMIT_STATS_EN adds saturating commit and full-stall counters.
package reg_pkg;
   localparam int unsigned NUM_ARCH_REGS = 32;
endpackage

module rob_commit_engine #(
   parameter int unsigned Q_DEPTH        = 64,
   parameter int unsigned DISPATCH_WIDTH = 4,
   parameter int unsigned COMMIT_WIDTH   = 4,
   parameter int unsigned WB_PORTS       = 2,
   parameter int unsigned ADDR_BITS      = 64,
   parameter int unsigned AREG_BITS      = $clog2(reg_pkg::NUM_ARCH_REGS),
   parameter logic [ADDR_BITS-1:0] EXC_VECTOR = '0
) (
   input  logic                                  clk_in,
   input  logic                                  rst_N_in,
   input  logic [$clog2(DISPATCH_WIDTH+1)-1:0]   enq_in,
   input  logic [DISPATCH_WIDTH*ADDR_BITS-1:0]   enq_pc_in,
   input  logic [DISPATCH_WIDTH*AREG_BITS-1:0]   enq_areg_in,
   input  logic [DISPATCH_WIDTH-1:0]             enq_store_in,
   output logic                                  enq_ack_out,
   output logic [$clog2(Q_DEPTH)-1:0]            alloc_idx_out,
   input  logic [WB_PORTS-1:0]                   wb_valid_in,
   input  logic [WB_PORTS*$clog2(Q_DEPTH)-1:0]   wb_idx_in,
   input  logic [WB_PORTS-1:0]                   wb_exc_in,
   output logic [COMMIT_WIDTH-1:0]               commit_valid_out,
   output logic [COMMIT_WIDTH*AREG_BITS-1:0]     commit_areg_out,
   output logic [COMMIT_WIDTH-1:0]               commit_store_out,
   output logic                                  valid_pc_out,
   output logic [ADDR_BITS-1:0]                  pc_out,
   output logic [ADDR_BITS-1:0]                  epc_out,
   output logic [$clog2(Q_DEPTH+1)-1:0]          size_out
`ifdef ROB_COMMIT_STATS_EN
   ,
   output logic [31:0]                           stat_commits_out,
   output logic [31:0]                           stat_full_stalls_out
`endif
);

   localparam int unsigned IDX_W  = $clog2(Q_DEPTH);
   localparam int unsigned PTR_W  = IDX_W + 1;
   localparam int unsigned ENQ_W  = $clog2(DISPATCH_WIDTH+1);
   localparam int unsigned SIZE_W = $clog2(Q_DEPTH+1);
   localparam int unsigned CNT_W  = $clog2(COMMIT_WIDTH+1);

   typedef enum logic [1:0] {ST_FREE, ST_PENDING, ST_DONE, ST_EXC} status_e;
   typedef enum logic {RUN, REDIRECT} state_e;

   state_e               state_q, state_d;
   logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
   status_e              status_q [Q_DEPTH];
   status_e              status_d [Q_DEPTH];
   logic [ADDR_BITS-1:0] pc_q     [Q_DEPTH];
   logic [AREG_BITS-1:0] areg_q   [Q_DEPTH];
   logic [Q_DEPTH-1:0]   store_q;

   logic [PTR_W-1:0]     size;
   logic [PTR_W-1:0]     free_slots;
   logic [IDX_W-1:0]     head_idx, tail_idx;
   logic [CNT_W-1:0]     commit_cnt;
   logic                 stop;

   assign size          = tail_q - head_q;
   assign free_slots    = PTR_W'(Q_DEPTH) - size;
   assign head_idx      = head_q[IDX_W-1:0];
   assign tail_idx      = tail_q[IDX_W-1:0];
   assign alloc_idx_out = tail_idx;
   assign size_out      = SIZE_W'(size);
   // Capacity check uses pre-commit occupancy; same-cycle retirements do not free slots.
   assign enq_ack_out   = (state_q == RUN) && (enq_in != '0) && (free_slots >= PTR_W'(enq_in));

   always_comb begin
      commit_valid_out = '0;
      commit_areg_out  = '0;
      commit_store_out = '0;
      commit_cnt       = '0;
      stop             = 1'b0;
      for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
         if (!stop && state_q == RUN && PTR_W'(i) < size &&
             status_q[head_idx + IDX_W'(i)] == ST_DONE) begin
            commit_valid_out[i]                    = 1'b1;
            commit_areg_out[i*AREG_BITS +: AREG_BITS] = areg_q[head_idx + IDX_W'(i)];
            commit_store_out[i]                    = store_q[head_idx + IDX_W'(i)];
            commit_cnt                             = commit_cnt + CNT_W'(1);
         end else begin
            stop = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      head_d       = head_q;
      tail_d       = tail_q;
      valid_pc_out = 1'b0;
      pc_out       = '0;
      epc_out      = '0;
      case (state_q)
         RUN: begin
            head_d = head_q + PTR_W'(commit_cnt);
            if (enq_ack_out) tail_d = tail_q + PTR_W'(enq_in);
            if (status_q[head_idx] == ST_EXC) state_d = REDIRECT;
         end
         REDIRECT: begin
            valid_pc_out = 1'b1;
            pc_out       = EXC_VECTOR;
            epc_out      = pc_q[head_idx];
            head_d       = '0;
            tail_d       = '0;
            state_d      = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // Update order: allocate, then writeback (higher port last), then free retired entries.
   always_comb begin
      for (int unsigned i = 0; i < Q_DEPTH; i++) status_d[i] = status_q[i];
      if (state_q == REDIRECT) begin
         for (int unsigned i = 0; i < Q_DEPTH; i++) status_d[i] = ST_FREE;
      end else begin
         if (enq_ack_out) begin
            for (int unsigned s = 0; s < DISPATCH_WIDTH; s++)
               if (ENQ_W'(s) < enq_in) status_d[tail_idx + IDX_W'(s)] = ST_PENDING;
         end
         for (int unsigned p = 0; p < WB_PORTS; p++) begin
            if (wb_valid_in[p] && status_q[wb_idx_in[p*IDX_W +: IDX_W]] != ST_FREE)
               status_d[wb_idx_in[p*IDX_W +: IDX_W]] = wb_exc_in[p] ? ST_EXC : ST_DONE;
         end
         for (int unsigned i = 0; i < COMMIT_WIDTH; i++)
            if (commit_valid_out[i]) status_d[head_idx + IDX_W'(i)] = ST_FREE;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_N_in) begin
         state_q <= RUN;
         head_q  <= '0;
         tail_q  <= '0;
         for (int unsigned i = 0; i < Q_DEPTH; i++) status_q[i] <= ST_FREE;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         for (int unsigned i = 0; i < Q_DEPTH; i++) status_q[i] <= status_d[i];
      end
   end

   always_ff @(posedge clk_in) begin
      if (enq_ack_out) begin
         for (int unsigned s = 0; s < DISPATCH_WIDTH; s++) begin
            if (ENQ_W'(s) < enq_in) begin
               pc_q[tail_idx + IDX_W'(s)]    <= enq_pc_in[s*ADDR_BITS +: ADDR_BITS];
               areg_q[tail_idx + IDX_W'(s)]  <= enq_areg_in[s*AREG_BITS +: AREG_BITS];
               store_q[tail_idx + IDX_W'(s)] <= enq_store_in[s];
            end
         end
      end
   end

`ifdef ROB_COMMIT_STATS_EN
   logic [31:0] stat_commits_q, stat_commits_d, stat_stalls_q, stat_stalls_d;
   logic [32:0] commit_sum;

   always_comb begin
      commit_sum     = {1'b0, stat_commits_q} + 33'(commit_cnt);
      stat_commits_d = commit_sum[32] ? '1 : commit_sum[31:0];
      stat_stalls_d  = stat_stalls_q;
      if (state_q == RUN && enq_in != '0 && !enq_ack_out && stat_stalls_q != '1)
         stat_stalls_d = stat_stalls_q + 32'd1;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_N_in) begin
         stat_commits_q <= '0;
         stat_stalls_q  <= '0;
      end else begin
         stat_commits_q <= stat_commits_d;
         stat_stalls_q  <= stat_stalls_d;
      end
   end

   assign stat_commits_out     = stat_commits_q;
   assign stat_full_stalls_out = stat_stalls_q;
`endif

endmodule

// File: tb/tb_rob_commit_engine.sv
// Randomised and directed bench for rob_commit_engine against a queue-level reference model.
// Stats counters are checked only when ROB_COMMIT_STATS_EN is defined.
module tb_rob_commit_engine;

   localparam logic [63:0] EXCV = 64'hFFFF_0000_0000_1000;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [2:0]   enq;
   logic [255:0] enq_pc;
   logic [19:0]  enq_areg;
   logic [3:0]   enq_store;
   logic         ack;
   logic [5:0]   alloc_idx;
   logic [1:0]   wb_valid;
   logic [11:0]  wb_idx;
   logic [1:0]   wb_exc;
   logic [3:0]   cvalid;
   logic [19:0]  careg;
   logic [3:0]   cstore;
   logic         vpc;
   logic [63:0]  pc_o, epc_o;
   logic [6:0]   size_o;
`ifdef ROB_COMMIT_STATS_EN
   logic [31:0]  st_commits, st_stalls;
   int           m_commits, m_stalls;
`endif

   always #5 clk = ~clk;

   rob_commit_engine #(.EXC_VECTOR(EXCV)) dut (
      .clk_in(clk), .rst_N_in(rst_n), .enq_in(enq), .enq_pc_in(enq_pc),
      .enq_areg_in(enq_areg), .enq_store_in(enq_store), .enq_ack_out(ack),
      .alloc_idx_out(alloc_idx), .wb_valid_in(wb_valid), .wb_idx_in(wb_idx),
      .wb_exc_in(wb_exc), .commit_valid_out(cvalid), .commit_areg_out(careg),
      .commit_store_out(cstore), .valid_pc_out(vpc), .pc_out(pc_o),
      .epc_out(epc_o), .size_out(size_o)
`ifdef ROB_COMMIT_STATS_EN
      , .stat_commits_out(st_commits), .stat_full_stalls_out(st_stalls)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: status 0=free 1=pending 2=done 3=exception
   int          m_st   [64];
   logic [63:0] m_pc   [64];
   logic [4:0]  m_areg [64];
   bit          m_store[64];
   int          m_head, m_size;
   bit          m_redir;

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_st[i] = 0;
      m_head = 0; m_size = 0; m_redir = 0;
`ifdef ROB_COMMIT_STATS_EN
      m_commits = 0; m_stalls = 0;
`endif
   endtask

   task automatic idle();
      enq = '0; wb_valid = '0; wb_exc = '0; wb_idx = '0;
   endtask

   task automatic set_enq(input int n, input logic [63:0] base);
      enq = 3'(n);
      for (int s = 0; s < 4; s++) begin
         enq_pc[s*64 +: 64] = base + 64'(4*s);
         enq_areg[s*5 +: 5] = 5'($urandom);
         enq_store[s]       = 1'($urandom);
      end
   endtask

   task automatic set_wb(input int p, input int idx, input bit exc);
      wb_valid[p]        = 1'b1;
      wb_idx[p*6 +: 6]   = 6'(idx);
      wb_exc[p]          = exc;
   endtask

   // One clock: inputs already driven; check combinational outputs, then advance the model.
   task automatic step();
      int n, e, h, idx;
      bit exp_ack;
      int old [64];
      logic [3:0]  exp_cv;
      logic [19:0] exp_ar;
      logic [3:0]  exp_cs;
      #1;
      n = 0; exp_ack = 0; e = int'(enq);
      if (!m_redir) begin
         exp_ack = (e != 0) && (64 - m_size >= e);
         while (n < 4 && n < m_size && m_st[(m_head + n) % 64] == 2) n++;
      end
      exp_cv = '0; exp_ar = '0; exp_cs = '0;
      for (int c = 0; c < n; c++) begin
         idx = (m_head + c) % 64;
         exp_cv[c] = 1'b1;
         exp_ar[c*5 +: 5] = m_areg[idx];
         exp_cs[c] = m_store[idx];
      end
      check_val("enq_ack", 64'(ack), 64'(exp_ack));
      check_val("alloc_idx", 64'(alloc_idx), 64'((m_head + m_size) % 64));
      check_val("size", 64'(size_o), 64'(m_size));
      check_val("commit_valid", 64'(cvalid), 64'(exp_cv));
      check_val("commit_areg", 64'(careg), 64'(exp_ar));
      check_val("commit_store", 64'(cstore), 64'(exp_cs));
      check_val("valid_pc", 64'(vpc), 64'(m_redir));
      check_val("pc_out", pc_o, m_redir ? EXCV : 64'd0);
      check_val("epc_out", epc_o, m_redir ? m_pc[m_head] : 64'd0);
`ifdef ROB_COMMIT_STATS_EN
      check_val("stat_commits", 64'(st_commits), 64'(m_commits));
      check_val("stat_stalls", 64'(st_stalls), 64'(m_stalls));
`endif
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else if (m_redir) begin
         for (int i = 0; i < 64; i++) m_st[i] = 0;
         m_head = 0; m_size = 0; m_redir = 0;
      end else begin
         for (int i = 0; i < 64; i++) old[i] = m_st[i];
         h = m_head;
         if (exp_ack) begin
            for (int s = 0; s < e; s++) begin
               idx = (h + m_size + s) % 64;
               m_st[idx]    = 1;
               m_pc[idx]    = enq_pc[s*64 +: 64];
               m_areg[idx]  = enq_areg[s*5 +: 5];
               m_store[idx] = enq_store[s];
            end
         end
         for (int p = 0; p < 2; p++) begin
            idx = int'(wb_idx[p*6 +: 6]);
            if (wb_valid[p] && old[idx] != 0) m_st[idx] = wb_exc[p] ? 3 : 2;
         end
         for (int c = 0; c < n; c++) m_st[(h + c) % 64] = 0;
         m_head = (h + n) % 64;
         m_size = m_size + (exp_ack ? e : 0) - n;
         m_redir = (old[h] == 3);
`ifdef ROB_COMMIT_STATS_EN
         m_commits += n;
         if (e != 0 && !exp_ack) m_stalls++;
`endif
      end
      @(negedge clk);
   endtask

   task automatic reset_dut();
      rst_n = 1'b0; idle();
      repeat (2) @(posedge clk);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic rand_wb(input int p, input int pct);
      int idx;
      if ($urandom_range(0, 99) >= pct) return;
      if (m_size > 0 && $urandom_range(0, 9) < 8) idx = (m_head + $urandom_range(0, m_size - 1)) % 64;
      else idx = $urandom_range(0, 63);
      if (m_st[idx] >= 2) return;
      set_wb(p, idx, $urandom_range(0, 24) == 0);
   endtask

   initial begin
      enq_pc = '0; enq_areg = '0; enq_store = '0;
      @(negedge clk);
      reset_dut();

      // Reset state, then 4-wide allocation
      idle(); step();
      idle(); set_enq(4, 64'h100); step();
      // Out-of-order completion, commit only once the prefix is done
      idle(); set_wb(0, 2, 0); set_wb(1, 3, 0); step();
      idle(); set_wb(0, 0, 0); set_wb(1, 1, 0); step();
      idle(); step();
      idle(); step();

      // Fill to full, then stall checks
      for (int k = 0; k < 16; k++) begin idle(); set_enq(4, 64'h2000 + 64'(k*16)); step(); end
      check_val("full_size", 64'(size_o), 64'd64);
      idle(); set_enq(1, 64'h3000); step();
      idle(); set_wb(0, m_head, 0); set_wb(1, (m_head + 1) % 64, 0); step();
      idle(); set_enq(4, 64'h3100); step();
      idle(); set_enq(4, 64'h3200); step();
      idle(); set_enq(2, 64'h3300); step();

      // Exception at idx1 behind a completed idx0
      reset_dut();
      idle(); set_enq(4, 64'h400); step();
      idle(); set_wb(0, 1, 1); set_wb(1, 0, 0); step();
      for (int k = 0; k < 4; k++) begin idle(); step(); end

      // Wrap-around: advance head to 62, then allocate across the boundary
      reset_dut();
      for (int k = 0; k < 15; k++) begin idle(); set_enq(4, 64'h5000 + 64'(k*16)); step(); end
      idle(); set_enq(2, 64'h5F00); step();
      for (int k = 0; k < 31; k++) begin idle(); set_wb(0, 2*k, 0); set_wb(1, 2*k + 1, 0); step(); end
      for (int k = 0; k < 20 && m_size != 0; k++) begin idle(); step(); end
      check_val("wrap_head_alloc", 64'(alloc_idx), 64'd62);
      idle(); set_enq(4, 64'h6000); step();
      idle(); set_wb(0, 63, 0); set_wb(1, 62, 0); step();
      idle(); set_wb(0, 1, 0); set_wb(1, 0, 0); step();
      idle(); step();
      idle(); step();

      // Same-index writeback on both ports, then reset during the redirect cycle
      reset_dut();
      idle(); set_enq(4, 64'h700); step();
      idle(); set_enq(4, 64'h710); step();
      idle(); set_wb(0, 5, 0); set_wb(1, 5, 1); step();
      idle(); set_wb(0, 0, 0); set_wb(1, 1, 0); step();
      idle(); set_wb(0, 2, 0); set_wb(1, 3, 0); step();
      idle(); set_wb(0, 4, 0); step();
      begin
         int k = 0;
         while (!m_redir && k < 30) begin idle(); step(); k++; end
         check_val("redirect_reached", 64'(m_redir), 64'd1);
      end
      idle(); rst_n = 1'b0; step();
      rst_n = 1'b1;
      idle(); step();
      check_val("post_reset_vpc", 64'(vpc), 64'd0);
      check_val("post_reset_size", 64'(size_o), 64'd0);

      // Randomised traffic with alternating fill and drain phases
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bit fill;
         fill = ((cyc / 150) % 2) == 0;
         idle();
         if ($urandom_range(0, 99) < (fill ? 80 : 15))
            set_enq($urandom_range(1, 4), {$urandom, $urandom});
         rand_wb(0, fill ? 30 : 90);
         rand_wb(1, fill ? 30 : 90);
         rst_n = ($urandom_range(0, 499) != 0);
         step();
         rst_n = 1'b1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
